// File: rtl/full_adder.sv
// One-bit full adder with a combinational result path and an enable-gated,
// synchronously reset registered copy of that result plus a valid flag.
module full_adder (
    input  logic iCLK,
    input  logic iRST,
    input  logic iX,
    input  logic iY,
    input  logic iCIN,
    input  logic iEN,
    output logic oSUM,
    output logic oCARRY,
    output logic oSUM_R,
    output logic oCARRY_R,
    output logic oVALID
);

    // Sum bit of a + b + c.
    function automatic logic addSum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Carry bit of a + b + c: set whenever at least two inputs are set.
    function automatic logic addCarry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic sum_p0;
    logic carry_p0;
    logic vld_p0;

    // Combinational result; deliberately independent of clock, reset and enable.
    always_comb begin
        oSUM   = addSum(iX, iY, iCIN);
        oCARRY = addCarry(iX, iY, iCIN);
    end

    // Stage p0: capture the combinational result on enabled edges; reset wins over enable
    // and also clears the result bits so a reset state never shows stale data.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sum_p0   <= 1'b0;
            carry_p0 <= 1'b0;
            vld_p0   <= 1'b0;
        end else if (iEN) begin
            sum_p0   <= addSum(iX, iY, iCIN);
            carry_p0 <= addCarry(iX, iY, iCIN);
            vld_p0   <= 1'b1;
        end
    end

    assign oSUM_R   = sum_p0;
    assign oCARRY_R = carry_p0;
    assign oVALID   = vld_p0;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: combinational sweep with clock/reset undriven,
// then reset, capture, hold, synchronous-reset timing, priority and back-to-back captures.
`timescale 1ns/1ps
module tb_full_adder;

    logic iCLK;
    logic iRST;
    logic iX;
    logic iY;
    logic iCIN;
    logic iEN;
    logic oSUM;
    logic oCARRY;
    logic oSUM_R;
    logic oCARRY_R;
    logic oVALID;

    int checks;
    int failures;
    bit clkRun;

    full_adder dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iX(iX),
        .iY(iY),
        .iCIN(iCIN),
        .iEN(iEN),
        .oSUM(oSUM),
        .oCARRY(oCARRY),
        .oSUM_R(oSUM_R),
        .oCARRY_R(oCARRY_R),
        .oVALID(oVALID)
    );

    // Clock toggles only once the bench starts it; before that iCLK stays undriven (X).
    always begin
        #5;
        if (clkRun) iCLK = ~iCLK;
    end

    // Global time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic test_comb_sweep();
        // {x, y, cin, sum, carry}
        logic [4:0] tbl [8];
        tbl = '{5'b000_00, 5'b100_10, 5'b010_10, 5'b110_01,
                5'b001_10, 5'b101_01, 5'b011_01, 5'b111_11};
        for (int i = 0; i < 8; i++) begin
            logic [4:0] v;
            v = tbl[i];
            iX = v[4]; iY = v[3]; iCIN = v[2];
            #100;
            checks++;
            if (oSUM !== v[1]) begin
                failures++;
                $display("FAIL comb_sum vec=%b actual=%b required=%b", v[4:2], oSUM, v[1]);
            end
            checks++;
            if (oCARRY !== v[0]) begin
                failures++;
                $display("FAIL comb_carry vec=%b actual=%b required=%b", v[4:2], oCARRY, v[0]);
            end
        end
    endtask

    task automatic test_reset();
        iCLK = 1'b0;
        iRST = 1'b1; iEN = 1'b1;
        iX = 1'b1; iY = 1'b1; iCIN = 1'b1;
        clkRun = 1'b1;
        @(posedge iCLK); #1;
        checks++;
        if (oSUM_R !== 1'b0) begin failures++; $display("FAIL reset_sum_r actual=%b required=0", oSUM_R); end
        checks++;
        if (oCARRY_R !== 1'b0) begin failures++; $display("FAIL reset_carry_r actual=%b required=0", oCARRY_R); end
        checks++;
        if (oVALID !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", oVALID); end
        checks++;
        if (oSUM !== 1'b1) begin failures++; $display("FAIL reset_comb_sum actual=%b required=1", oSUM); end
        checks++;
        if (oCARRY !== 1'b1) begin failures++; $display("FAIL reset_comb_carry actual=%b required=1", oCARRY); end
        // Out of reset but disabled: valid must stay low.
        @(negedge iCLK);
        iRST = 1'b0; iEN = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        checks++;
        if (oVALID !== 1'b0) begin failures++; $display("FAIL reset_valid_idle actual=%b required=0", oVALID); end
    endtask

    task automatic test_capture();
        @(negedge iCLK);
        iRST = 1'b0; iEN = 1'b1;
        iX = 1'b1; iY = 1'b1; iCIN = 1'b0;
        @(posedge iCLK); #1;
        checks++;
        if (oSUM_R !== 1'b0) begin failures++; $display("FAIL capture_sum_r actual=%b required=0", oSUM_R); end
        checks++;
        if (oCARRY_R !== 1'b1) begin failures++; $display("FAIL capture_carry_r actual=%b required=1", oCARRY_R); end
        checks++;
        if (oVALID !== 1'b1) begin failures++; $display("FAIL capture_valid actual=%b required=1", oVALID); end
    endtask

    task automatic test_hold();
        @(negedge iCLK);
        iEN = 1'b0;
        iX = 1'b0; iY = 1'b0; iCIN = 1'b1;
        #1;
        checks++;
        if (oSUM !== 1'b1) begin failures++; $display("FAIL hold_comb_sum actual=%b required=1", oSUM); end
        checks++;
        if (oCARRY !== 1'b0) begin failures++; $display("FAIL hold_comb_carry actual=%b required=0", oCARRY); end
        for (int i = 0; i < 3; i++) begin
            @(posedge iCLK); #1;
            checks++;
            if ({oSUM_R, oCARRY_R, oVALID} !== 3'b011) begin
                failures++;
                $display("FAIL hold_regs edge=%0d actual=%b required=011", i, {oSUM_R, oCARRY_R, oVALID});
            end
        end
        // Enable mid-cycle with new inputs: nothing changes until the next edge.
        iEN = 1'b1; iX = 1'b1; iY = 1'b1; iCIN = 1'b1;
        #2;
        checks++;
        if ({oSUM_R, oCARRY_R, oVALID} !== 3'b011) begin
            failures++;
            $display("FAIL between_edges actual=%b required=011", {oSUM_R, oCARRY_R, oVALID});
        end
        @(posedge iCLK); #1;
        checks++;
        if ({oSUM_R, oCARRY_R, oVALID} !== 3'b111) begin
            failures++;
            $display("FAIL between_edges_load actual=%b required=111", {oSUM_R, oCARRY_R, oVALID});
        end
    endtask

    task automatic test_priority();
        @(negedge iCLK);
        iRST = 1'b1; iEN = 1'b1;
        iX = 1'b1; iY = 1'b1; iCIN = 1'b1;
        #1;
        // Reset is synchronous: no change before the edge, combinational path untouched.
        checks++;
        if ({oSUM_R, oCARRY_R, oVALID} !== 3'b111) begin
            failures++;
            $display("FAIL sync_reset_pre_edge actual=%b required=111", {oSUM_R, oCARRY_R, oVALID});
        end
        checks++;
        if ({oCARRY, oSUM} !== 2'b11) begin
            failures++;
            $display("FAIL reset_comb_unaffected actual=%b required=11", {oCARRY, oSUM});
        end
        @(posedge iCLK); #1;
        checks++;
        if ({oSUM_R, oCARRY_R, oVALID} !== 3'b000) begin
            failures++;
            $display("FAIL priority_reset actual=%b required=000", {oSUM_R, oCARRY_R, oVALID});
        end
        @(negedge iCLK);
        iRST = 1'b0; iEN = 1'b1;
        iX = 1'b1; iY = 1'b0; iCIN = 1'b1;
        @(posedge iCLK); #1;
        checks++;
        if ({oSUM_R, oCARRY_R, oVALID} !== 3'b011) begin
            failures++;
            $display("FAIL priority_recapture actual=%b required=011", {oSUM_R, oCARRY_R, oVALID});
        end
    endtask

    task automatic test_back_to_back();
        // {x, y, cin, sum, carry} on consecutive enabled edges
        logic [4:0] tbl [8];
        tbl = '{5'b111_11, 5'b000_00, 5'b011_01, 5'b100_10,
                5'b101_01, 5'b010_10, 5'b001_10, 5'b110_01};
        for (int i = 0; i < 8; i++) begin
            logic [4:0] v;
            v = tbl[i];
            @(negedge iCLK);
            iRST = 1'b0; iEN = 1'b1;
            iX = v[4]; iY = v[3]; iCIN = v[2];
            @(posedge iCLK); #1;
            checks++;
            if ({oSUM_R, oCARRY_R, oVALID} !== {v[1], v[0], 1'b1}) begin
                failures++;
                $display("FAIL b2b_regs vec=%b actual=%b required=%b",
                         v[4:2], {oSUM_R, oCARRY_R, oVALID}, {v[1], v[0], 1'b1});
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clkRun   = 1'b0;
        iCLK     = 1'bx;
        iRST     = 1'bx;
        iEN      = 1'b0;
        iX       = 1'b0;
        iY       = 1'b0;
        iCIN     = 1'b0;
        test_comb_sweep();
        test_reset();
        test_capture();
        test_hold();
        test_priority();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
